// File: rtl/inst_fetch_unit.sv
// inst_fetch_unit
//   Instruction-fetch stage of the pipelined RV64 core, directly upstream of
//   the IF/ID pipeline register. Owns the PC and keeps at most one request
//   outstanding on the instruction-memory req/gnt/rvalid handshake.
//
// Ports
//   clk, rst_n                 rising-edge clock, asynchronous active-low reset
//   stall                      hold presented outputs (same as IF/ID stall)
//   redirect, redirect_pc      restart fetch at redirect_pc (bits [1:0] forced to 0)
//   imem_req, imem_addr        fetch request valid / address (= pc register)
//   imem_gnt                   memory accepts the request this cycle
//   imem_rvalid, imem_rdata    response valid / 32-bit instruction word
//   out_pc, out_inst, out_valid  presented instruction to IF/ID (valid=0 is a bubble)
module inst_fetch_unit #(
  parameter logic [63:0] RESET_PC = 64'h0000_0000_0000_0000,
  parameter int          INST_W   = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              stall,
  input  logic              redirect,
  input  logic [63:0]       redirect_pc,
  output logic              imem_req,
  output logic [63:0]       imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  output logic [63:0]       out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic              out_valid
);

  localparam logic [INST_W-1:0] NOP_INST = {{(INST_W-32){1'b0}}, 32'h0000_0013};

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2,
    S_DROP  = 2'd3
  } state_e;

  state_e              state_q, state_d;
  logic [63:0]         pc_q, pc_d;
  logic [63:0]         out_pc_q, out_pc_d;
  logic [INST_W-1:0]   out_inst_q, out_inst_d;
  logic                out_valid_q, out_valid_d;
  logic [63:0]         hold_pc_q, hold_pc_d;
  logic [31:0]         hold_inst_q, hold_inst_d;

  // Next-state and next-output computation for the fetch FSM.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    out_pc_d    = out_pc_q;
    out_inst_d  = out_inst_q;
    // Without stall, any cycle that presents nothing new becomes a bubble.
    out_valid_d = stall ? out_valid_q : 1'b0;
    hold_pc_d   = hold_pc_q;
    hold_inst_d = hold_inst_q;

    if (redirect) begin
      pc_d        = redirect_pc & ~64'd3;
      out_valid_d = 1'b0;
      hold_pc_d   = 64'd0;
      hold_inst_d = 32'd0;
      case (state_q)
        S_FETCH: state_d = imem_gnt ? S_DROP : S_FETCH;
        S_WAIT:  state_d = imem_rvalid ? S_FETCH : S_DROP;
        S_HOLD:  state_d = S_FETCH;
        // A response landing in the same cycle retires the abandoned request,
        // otherwise keep waiting for it.
        S_DROP:  state_d = imem_rvalid ? S_FETCH : S_DROP;
        default: state_d = S_FETCH;
      endcase
    end else begin
      case (state_q)
        S_FETCH: begin
          if (imem_gnt) begin
            state_d = S_WAIT;
          end else begin
            state_d = S_FETCH;
          end
        end
        S_WAIT: begin
          if (imem_rvalid) begin
            pc_d = pc_q + 64'd4;
            if (!stall) begin
              out_pc_d    = pc_q;
              out_inst_d  = {{(INST_W-32){1'b0}}, imem_rdata};
              out_valid_d = 1'b1;
              state_d     = S_FETCH;
            end else begin
              hold_pc_d   = pc_q;
              hold_inst_d = imem_rdata;
              state_d     = S_HOLD;
            end
          end else begin
            state_d = S_WAIT;
          end
        end
        S_HOLD: begin
          if (!stall) begin
            out_pc_d    = hold_pc_q;
            out_inst_d  = {{(INST_W-32){1'b0}}, hold_inst_q};
            out_valid_d = 1'b1;
            state_d     = S_FETCH;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_DROP: begin
          if (imem_rvalid) begin
            state_d = S_FETCH;
          end else begin
            state_d = S_DROP;
          end
        end
        default: state_d = S_FETCH;
      endcase
    end
  end

  // State, PC, hold buffer and presented-output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_FETCH;
      pc_q        <= RESET_PC;
      out_pc_q    <= 64'd0;
      out_inst_q  <= NOP_INST;
      out_valid_q <= 1'b0;
      hold_pc_q   <= 64'd0;
      hold_inst_q <= 32'd0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_pc_q    <= out_pc_d;
      out_inst_q  <= out_inst_d;
      out_valid_q <= out_valid_d;
      hold_pc_q   <= hold_pc_d;
      hold_inst_q <= hold_inst_d;
    end
  end

  // Request is held low while reset is asserted even though state reads FETCH.
  assign imem_req  = rst_n & (state_q == S_FETCH);
  assign imem_addr = pc_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;
  assign out_valid = out_valid_q;

endmodule
